vid_sync_out: RTL

- Final output stage of the video pipeline. Sits directly downstream of the shift-register stage.
- Consumes the serial pixel and the pipelined hblank/vblank flags. Produces registered, aligned pixel, blank, hsync and vsync outputs for the display, plus a frame-start strobe.
- Sync pulses are placed inside the blanking intervals by porch/width counters, so sync placement needs no change to the timing generator.

---
 rtl/vid_sync_out.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vid_sync_out.sv
// Video output stage: registers pixel/blank and places hsync/vsync pulses
// inside the blanking intervals using porch/width counters.
module vid_sync_out #(
  parameter int HFP  = 1,
  parameter int HSW  = 1,
  parameter int VFP  = 0,
  parameter int VSW  = 1,
  parameter int HPOL = 0,
  parameter int VPOL = 0,
  parameter int CW   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pixel_in,
  input  logic hblank_in,
  input  logic vblank_in,
  output logic pixel_out,
  output logic blank_out,
  output logic hsync_out,
  output logic vsync_out,
  output logic frame_start,
  output logic sync_trunc
);
  typedef enum logic [1:0] {H_ACT, H_FP, H_SYNC, H_BP} hst_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYNC, V_BP} vst_t;

  localparam logic [CW:0] ONE   = (CW+1)'(1);
  localparam logic [CW:0] HFP_W = (CW+1)'(HFP);
  localparam logic [CW:0] HEND  = (CW+1)'(HFP + HSW);
  localparam logic [CW:0] VFP_W = (CW+1)'(VFP);
  localparam logic [CW:0] VEND  = (CW+1)'(VFP + VSW);
  localparam logic        HACT  = 1'(HPOL);
  localparam logic        VACT  = 1'(VPOL);

  hst_t          hst_q, hst_d;
  vst_t          vst_q, vst_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vline_q, vline_d;
  logic          hb_q, vb_q, pend_q, pend_d;
  logic          pixel_q, pixel_d, blank_q, blank_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          fs_q, fs_d, trunc_q, trunc_d;

  // Vertical phase is a pure function of the line number within vblank.
  function automatic vst_t vphase(input logic [CW-1:0] line);
    logic [CW:0] l;
    l = {1'b0, line};
    if (l + ONE <= VFP_W) return V_FP;
    else if (l < VEND)    return V_SYNC;
    else                  return V_BP;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hst_q   <= H_ACT;
      vst_q   <= V_ACT;
      hcnt_q  <= '0;
      vline_q <= '0;
      hb_q    <= 1'b1;
      vb_q    <= 1'b1;
      pend_q  <= 1'b0;
      pixel_q <= 1'b0;
      blank_q <= 1'b1;
      hsync_q <= ~HACT;
      vsync_q <= ~VACT;
      fs_q    <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      hst_q   <= hst_d;
      vst_q   <= vst_d;
      hcnt_q  <= hcnt_d;
      vline_q <= vline_d;
      hb_q    <= hblank_in;
      vb_q    <= vblank_in;
      pend_q  <= pend_d;
      pixel_q <= pixel_d;
      blank_q <= blank_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    hst_d   = hst_q;
    vst_d   = vst_q;
    hcnt_d  = hcnt_q;
    vline_d = vline_q;
    pend_d  = pend_q;
    trunc_d = trunc_q;
    fs_d    = 1'b0;

    // Horizontal: only a real hblank rising edge (hb_q=0) starts sequencing.
    if (!hblank_in) begin
      hst_d  = H_ACT;
      hcnt_d = '0;
      if (hst_q == H_SYNC && ({1'b0, hcnt_q} + ONE < HEND)) trunc_d = 1'b1;
    end else if (!hb_q) begin
      hcnt_d = '0;
      hst_d  = (HFP == 0) ? H_SYNC : H_FP;
    end else if (hst_q != H_ACT) begin
      hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + CW'(1);
      case (hst_q)
        H_FP:    if ({1'b0, hcnt_d} == HFP_W) hst_d = H_SYNC;
        H_SYNC:  if ({1'b0, hcnt_d} == HEND)  hst_d = H_BP;
        default: ;
      endcase
    end

    // Vertical: line counter advances on hblank falling edges inside vblank.
    if (!vblank_in) begin
      vst_d   = V_ACT;
      vline_d = '0;
      if (vst_q == V_SYNC && ({1'b0, vline_q} + ONE < VEND)) trunc_d = 1'b1;
    end else if (!vb_q) begin
      vline_d = '0;
      vst_d   = vphase('0);
    end else if (vst_q != V_ACT) begin
      if (hb_q && !hblank_in && vline_q != '1) vline_d = vline_q + CW'(1);
      vst_d = vphase(vline_d);
    end

    // Frame start waits for the first cycle with both blanks low.
    if (vblank_in)  pend_d = 1'b0;
    else if (vb_q)  pend_d = 1'b1;
    if (pend_d && !vblank_in && !hblank_in) begin
      fs_d   = 1'b1;
      pend_d = 1'b0;
    end

    pixel_d = pixel_in & ~hblank_in & ~vblank_in;
    blank_d = hblank_in | vblank_in;
    hsync_d = (hst_d == H_SYNC) ? HACT : ~HACT;
    vsync_d = (vst_d == V_SYNC) ? VACT : ~VACT;
  end

  assign pixel_out   = pixel_q;
  assign blank_out   = blank_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_start = fs_q;
  assign sync_trunc  = trunc_q;
endmodule
